// File: rtl/usb_rst_seq_pkg.sv
// Shared types and constants for the USB chip reset sequencer.
package usb_rst_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PULSE  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_SETTLE = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd3;

  // CTRL write-side bits
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_CLR_DONE = 2;
  localparam int unsigned CTRL_FORCE    = 3;
  // CTRL read-side bits
  localparam int unsigned CTRL_BUSY      = 0;
  localparam int unsigned CTRL_DONE      = 2;
  localparam int unsigned CTRL_STATE_LSB = 4;

  // Counter preload for a phase: a zero length behaves as one cycle.
  function automatic logic [DATA_W-1:0] phase_load(input logic [DATA_W-1:0] len);
    return (len == '0) ? '0 : len - DATA_W'(1);
  endfunction

endpackage

// File: rtl/usb_reset_sequencer_if.sv
// Avalon-MM slave bus (readLatency 0) between the interconnect and the sequencer.
interface usb_reset_sequencer_if;
  import usb_rst_seq_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/usb_rst_seq_timer.sv
// Loadable down-counter that parks at zero; used for both reset phases.
module usb_rst_seq_timer #(
  parameter int unsigned      CNT_W     = 24,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/usb_reset_sequencer.sv
// Timed reset generator for the USB host chip: hold usb_rst for PULSE_LEN cycles,
// wait SETTLE_LEN cycles, then flag DONE (optionally interrupting).
module usb_reset_sequencer
  import usb_rst_seq_pkg::*;
#(
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] DEFAULT_PULSE  = CNT_W'(500000),
  parameter logic [CNT_W-1:0] DEFAULT_SETTLE = CNT_W'(250000),
  parameter bit               AUTO_START     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  usb_reset_sequencer_if.slave  bus,
  output logic                  usb_rst,
  output logic                  irq
);

  localparam state_e           ST_RESET  = AUTO_START ? ST_ASSERT : ST_IDLE;
  localparam logic [CNT_W-1:0] CNT_RESET =
    AUTO_START ? CNT_W'(phase_load(DATA_W'(DEFAULT_PULSE))) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pulse_len_q;
  logic [CNT_W-1:0] settle_len_q;
  logic             irq_en_q;
  logic             force_q;
  logic             done_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_zero;
  logic             done_set;

  logic             wr_c;
  logic             wr_ctrl_c;
  logic             start_c;
  logic             busy_c;
  logic [DATA_W-1:0] rdata_c;
  logic             unused_wdata;

  assign wr_c      = bus.chipselect & ~bus.write_n;
  assign wr_ctrl_c = wr_c && (bus.address == ADDR_CTRL);
  assign start_c   = wr_ctrl_c && bus.writedata[CTRL_START];
  assign busy_c    = (state_q != ST_IDLE);
  assign unused_wdata = ^bus.writedata;

  usb_rst_seq_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (CNT_RESET)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and timer control; lengths are sampled only at phase load
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    done_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d      = ST_ASSERT;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(phase_load(DATA_W'(pulse_len_q)));
        end
      end
      ST_ASSERT: begin
        if (tmr_zero) begin
          state_d      = ST_SETTLE;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(phase_load(DATA_W'(settle_len_q)));
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file; completion beats a simultaneous CLR_DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_len_q  <= DEFAULT_PULSE;
      settle_len_q <= DEFAULT_SETTLE;
      irq_en_q     <= 1'b0;
      force_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (wr_c && (bus.address == ADDR_PULSE)) begin
        pulse_len_q <= bus.writedata[CNT_W-1:0];
      end
      if (wr_c && (bus.address == ADDR_SETTLE)) begin
        settle_len_q <= bus.writedata[CNT_W-1:0];
      end
      if (wr_ctrl_c) begin
        irq_en_q <= bus.writedata[CTRL_IRQ_EN];
        force_q  <= bus.writedata[CTRL_FORCE];
      end
      if (done_set) begin
        done_q <= 1'b1;
      end else if (wr_ctrl_c && bus.writedata[CTRL_CLR_DONE]) begin
        done_q <= 1'b0;
      end
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    rdata_c = '0;
    case (bus.address)
      ADDR_CTRL: begin
        rdata_c[CTRL_BUSY]                = busy_c;
        rdata_c[CTRL_IRQ_EN]              = irq_en_q;
        rdata_c[CTRL_DONE]                = done_q;
        rdata_c[CTRL_FORCE]               = force_q;
        rdata_c[CTRL_STATE_LSB +: 2]      = state_q;
      end
      ADDR_PULSE:  rdata_c = DATA_W'(pulse_len_q);
      ADDR_SETTLE: rdata_c = DATA_W'(settle_len_q);
      ADDR_COUNT:  rdata_c = DATA_W'(tmr_count);
      default:     rdata_c = '0;
    endcase
  end

  assign bus.readdata = rdata_c;
  assign usb_rst      = (state_q == ST_ASSERT) | force_q;
  assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_usb_reset_sequencer.sv
// Directed self-checking bench for usb_reset_sequencer (AUTO_START, pulse 4, settle 3).
module tb_usb_reset_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic usb_rst;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  usb_reset_sequencer_if bus();

  usb_reset_sequencer #(
    .CNT_W          (24),
    .DEFAULT_PULSE  (24'd4),
    .DEFAULT_SETTLE (24'd3),
    .AUTO_START     (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .usb_rst (usb_rst),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
    bus.address = addr;
    #1;
    data = bus.readdata;
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
    tick();
    tick();
    checks++; if (usb_rst !== 1'b1) begin errors++; $display("FAIL reset_usb_rst got %b exp 1", usb_rst); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL reset_ctrl got %h exp 11", rd); end
    read_reg(2'd1, rd);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL reset_pulse got %0d exp 4", rd); end
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL reset_settle got %0d exp 3", rd); end
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL reset_count got %0d exp 3", rd); end
  endtask

  task automatic test_auto_start();
    logic [31:0] rd;
    int rst_cyc = 0;
    int busy_cyc = 0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      read_reg(2'd0, rd);
      if (usb_rst) rst_cyc++;
      if (rd[0]) busy_cyc++;
      tick();
    end
    checks++; if (rst_cyc != 4) begin errors++; $display("FAIL auto_rst_cycles got %0d exp 4", rst_cyc); end
    checks++; if (busy_cyc != 7) begin errors++; $display("FAIL auto_busy_cycles got %0d exp 7", busy_cyc); end
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL auto_ctrl_done got %h exp 4", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL auto_irq got %b exp 0", irq); end
  endtask

  task automatic test_zero_len();
    logic [31:0] rd;
    write_reg(2'd0, 32'h4);
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL zl_clr_done got %h exp 0", rd); end
    write_reg(2'd1, 32'h0);
    write_reg(2'd2, 32'h0);
    write_reg(2'd0, 32'h3);
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h13 || usb_rst !== 1'b1) begin errors++; $display("FAIL zl_assert got ctrl %h rst %b exp 13 1", rd, usb_rst); end
    tick();
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h23 || usb_rst !== 1'b0) begin errors++; $display("FAIL zl_settle got ctrl %h rst %b exp 23 0", rd, usb_rst); end
    tick();
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h6 || irq !== 1'b1) begin errors++; $display("FAIL zl_done got ctrl %h irq %b exp 6 1", rd, irq); end
    write_reg(2'd0, 32'h6);
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h2 || irq !== 1'b0) begin errors++; $display("FAIL zl_clear got ctrl %h irq %b exp 2 0", rd, irq); end
  endtask

  task automatic test_length_during_sequence();
    logic [31:0] rd;
    int rst_cyc = 0;
    write_reg(2'd1, 32'd10);
    write_reg(2'd0, 32'h3);
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd9) begin errors++; $display("FAIL len_count0 got %0d exp 9", rd); end
    write_reg(2'd0, 32'h3);
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL len_restart_ignored got %0d exp 8", rd); end
    write_reg(2'd1, 32'd2);
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd7) begin errors++; $display("FAIL len_write_live got %0d exp 7", rd); end
    for (int k = 3; k < 10; k++) begin
      tick();
      read_reg(2'd3, rd);
      checks++; if (rd !== 32'(9 - k) || usb_rst !== 1'b1) begin errors++; $display("FAIL len_count_k%0d got %0d rst %b exp %0d 1", k, rd, usb_rst, 9 - k); end
    end
    tick();
    checks++; if (usb_rst !== 1'b0) begin errors++; $display("FAIL len_pulse_end got %b exp 0", usb_rst); end
    tick();
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h6 || irq !== 1'b1) begin errors++; $display("FAIL len_done got ctrl %h irq %b exp 6 1", rd, irq); end
    read_reg(2'd1, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL len_pulse_reg got %0d exp 2", rd); end
    write_reg(2'd0, 32'h3);
    for (int i = 0; i < 10; i++) begin
      if (usb_rst) rst_cyc++;
      tick();
    end
    checks++; if (rst_cyc != 2) begin errors++; $display("FAIL len_next_pulse got %0d exp 2", rst_cyc); end
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL len_next_done got %h exp 6", rd); end
  endtask

  task automatic test_clr_done_race();
    logic [31:0] rd;
    write_reg(2'd0, 32'h7);
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h13) begin errors++; $display("FAIL race_start_clr got %h exp 13", rd); end
    tick();
    tick();
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h23) begin errors++; $display("FAIL race_settle got %h exp 23", rd); end
    write_reg(2'd0, 32'h6);
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h6 || irq !== 1'b1) begin errors++; $display("FAIL race_set_wins got ctrl %h irq %b exp 6 1", rd, irq); end
    write_reg(2'd0, 32'hC);
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h8 || usb_rst !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL force_idle got ctrl %h rst %b irq %b exp 8 1 0", rd, usb_rst, irq); end
    tick();
    tick();
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd0 || usb_rst !== 1'b1) begin errors++; $display("FAIL force_hold got count %0d rst %b exp 0 1", rd, usb_rst); end
    write_reg(2'd0, 32'h0);
    checks++; if (usb_rst !== 1'b0) begin errors++; $display("FAIL force_release got %b exp 0", usb_rst); end
  endtask

  task automatic test_reset_mid_settle();
    logic [31:0] rd;
    write_reg(2'd1, 32'd5);
    write_reg(2'd2, 32'd6);
    write_reg(2'd0, 32'hB);
    for (int i = 0; i < 5; i++) tick();
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h2B) begin errors++; $display("FAIL mid_settle_ctrl got %h exp 2b", rd); end
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL mid_settle_count got %0d exp 5", rd); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_reg(2'd0, rd);
    checks++; if (rd !== 32'h11 || irq !== 1'b0 || usb_rst !== 1'b1) begin errors++; $display("FAIL abort_ctrl got %h irq %b rst %b exp 11 0 1", rd, irq, usb_rst); end
    read_reg(2'd1, rd);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL abort_pulse got %0d exp 4", rd); end
    read_reg(2'd2, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL abort_settle got %0d exp 3", rd); end
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL abort_count got %0d exp 3", rd); end
    tick();
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL count_read got %0d exp 2", rd); end
    write_reg(2'd3, 32'h55);
    read_reg(2'd3, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL count_write_ignored got %0d exp 1", rd); end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_zero_len();
    test_length_during_sequence();
    test_clr_done_race();
    test_reset_mid_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
